reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_pkg.sv | 35 +++
 rtl/reg_writeback_byte_sel.sv | 20 ++
 rtl/reg_writeback.sv | 124 ++++++++++++
 tb/tb_reg_writeback.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared widths, register indices and result-source decode for the writeback stage.
`ifndef REG_WRITEBACK_DEFINES
`define REG_WRITEBACK_DEFINES
`define FULLW 32
`define WIDTH 32
`define WORD [`FULLW-1:0]
`endif

package reg_writeback_pkg;

    localparam int FULLW  = `FULLW;
    localparam int LR_IDX = 14;
    localparam int PC_IDX = 15;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_WORD = 2'd1,
        SRC_BYTE = 2'd2,
        SRC_LINK = 2'd3
    } wb_src_e;

    // Link outranks load, and a byte load outranks a word load.
    function automatic wb_src_e wb_src(input logic link, input logic is_load,
                                       input logic is_byte);
        if (link)
            return SRC_LINK;
        else if (is_load && is_byte)
            return SRC_BYTE;
        else if (is_load)
            return SRC_WORD;
        else
            return SRC_ALU;
    endfunction

endpackage

// File: rtl/reg_writeback_byte_sel.sv
// Big-endian byte extract for ldrb: byte 0 is word[31:24], result zero-extended.
module wb_byte_sel
    import reg_writeback_pkg::*;
(
    input  logic [FULLW-1:0] word,
    input  logic [1:0]       off,
    output logic [FULLW-1:0] byte_z
);

    always_comb begin
        byte_z = '0;
        case (off)
            2'd0:    byte_z[7:0] = word[31:24];
            2'd1:    byte_z[7:0] = word[23:16];
            2'd2:    byte_z[7:0] = word[15:8];
            default: byte_z[7:0] = word[7:0];
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: selects the retiring result, issues it to the register file or PC
// one cycle later, forwards it over the registered RF read, and tracks in-flight writes.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    // m_valid has no ready: a result is accepted every cycle it is high, never stalled.
    input  logic                       m_valid,
    input  logic [ADDR_WIDTH-1:0]      m_wa,
    input  logic [FULLW-1:0]           m_alu,
    input  logic                       m_is_load,
    input  logic                       m_is_byte,
    input  logic                       m_link,
    input  logic [FULLW-1:0]           m_ld_data,
    input  logic [1:0]                 m_byte_off,
    input  logic [FULLW-1:0]           m_pc,
    input  logic [ADDR_WIDTH-1:0]      rn_a,
    input  logic [ADDR_WIDTH-1:0]      rm_a,
    input  logic [FULLW-1:0]           rn_rf,
    input  logic [FULLW-1:0]           rm_rf,
    output logic                       we,
    output logic [ADDR_WIDTH-1:0]      wa,
    output logic [FULLW-1:0]           wd,
    output logic                       pc_we,
    output logic [FULLW-1:0]           pc_wd,
    output logic [FULLW-1:0]           rn_fwd,
    output logic [FULLW-1:0]           rm_fwd,
    output logic [(1<<ADDR_WIDTH)-1:0] pending
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] dest;
    logic [FULLW-1:0]      byte_val;
    logic [FULLW-1:0]      res;
    logic                  to_pc;
    logic                  to_rf;
    logic [NREG-1:0]       set_mask;
    logic [NREG-1:0]       clr_mask;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] wa_q;
    logic [FULLW-1:0]      wd_q;
    logic [ADDR_WIDTH-1:0] rn_q;
    logic [ADDR_WIDTH-1:0] rm_q;

    wb_byte_sel u_byte_sel (
        .word   (m_ld_data),
        .off    (m_byte_off),
        .byte_z (byte_val)
    );

    always_comb begin
        dest = m_link ? ADDR_WIDTH'(LR_IDX) : m_wa;
        res  = m_alu;
        case (wb_src(m_link, m_is_load, m_is_byte))
            SRC_LINK: res = m_pc + 32'd4;
            SRC_BYTE: res = byte_val;
            SRC_WORD: res = m_ld_data;
            default:  res = m_alu;
        endcase
        to_pc = (dest == ADDR_WIDTH'(PC_IDX));
        to_rf = m_valid && !to_pc;
    end

    // A register re-captured on the edge its previous write issues stays pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (m_valid)
            set_mask = NREG'(1) << dest;
        if (we)
            clr_mask = NREG'(1) << wa;
        else if (pc_we)
            clr_mask = NREG'(1) << PC_IDX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we      <= 1'b0;
            wa      <= '0;
            wd      <= '0;
            pc_we   <= 1'b0;
            pc_wd   <= '0;
            pending <= '0;
        end else begin
            we      <= to_rf;
            pc_we   <= m_valid && to_pc;
            if (to_rf) begin
                wa <= dest;
                wd <= res;
            end
            if (m_valid && to_pc)
                pc_wd <= res;
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // The RF read returns pre-write contents, so remember the write that lands with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
            rn_q <= '0;
            rm_q <= '0;
        end else begin
            we_q <= we;
            wa_q <= wa;
            wd_q <= wd;
            rn_q <= rn_a;
            rm_q <= rm_a;
        end
    end

    always_comb begin
        rn_fwd = (we_q && (wa_q == rn_q)) ? wd_q : rn_rf;
        rm_fwd = (we_q && (wa_q == rm_q)) ? wd_q : rm_rf;
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios then random traffic against an
// architectural register-file model with per-register in-flight counts.
module tb_reg_writeback;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_valid;
    logic [AW-1:0] m_wa;
    logic [31:0]   m_alu;
    logic          m_is_load;
    logic          m_is_byte;
    logic          m_link;
    logic [31:0]   m_ld_data;
    logic [1:0]    m_byte_off;
    logic [31:0]   m_pc;
    logic [AW-1:0] rn_a;
    logic [AW-1:0] rm_a;
    logic [31:0]   rn_rf;
    logic [31:0]   rm_rf;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic          pc_we;
    logic [31:0]   pc_wd;
    logic [31:0]   rn_fwd;
    logic [31:0]   rm_fwd;
    logic [15:0]   pending;

    always #5 clk = ~clk;

    reg_writeback #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_valid    (m_valid),
        .m_wa       (m_wa),
        .m_alu      (m_alu),
        .m_is_load  (m_is_load),
        .m_is_byte  (m_is_byte),
        .m_link     (m_link),
        .m_ld_data  (m_ld_data),
        .m_byte_off (m_byte_off),
        .m_pc       (m_pc),
        .rn_a       (rn_a),
        .rm_a       (rm_a),
        .rn_rf      (rn_rf),
        .rm_rf      (rm_rf),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .pc_we      (pc_we),
        .pc_wd      (pc_wd),
        .rn_fwd     (rn_fwd),
        .rm_fwd     (rm_fwd),
        .pending    (pending)
    );

    int total = 0;
    int bad   = 0;

    // Architectural model: register contents and writes still in flight per register.
    logic [31:0] rf_m [16];
    int          inflight [16];
    logic        e_we;
    logic        e_pc_we;
    logic [3:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_pc_wd;
    logic [31:0] e_rn_fwd;
    logic [31:0] e_rm_fwd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        e_we    = 1'b0;
        e_pc_we = 1'b0;
        e_wa    = '0;
        e_wd    = '0;
        e_pc_wd = '0;
        for (int i = 0; i < 16; i++) inflight[i] = 0;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [31:0] alu,
                         input logic ld, input logic byt, input logic lnk,
                         input logic [31:0] ldd, input logic [1:0] off,
                         input logic [31:0] pc, input logic [3:0] rn, input logic [3:0] rm);
        m_valid    = v;
        m_wa       = a;
        m_alu      = alu;
        m_is_load  = ld;
        m_is_byte  = byt;
        m_link     = lnk;
        m_ld_data  = ldd;
        m_byte_off = off;
        m_pc       = pc;
        rn_a       = rn;
        rm_a       = rm;
    endtask

    task automatic idle(input logic [3:0] rn, input logic [3:0] rm);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0, rn, rm);
    endtask

    // One clock: advance the model with the inputs taken at the edge, then check every output.
    task automatic step();
        logic [3:0]  d;
        logic [31:0] v;
        logic [15:0] ep;
        @(posedge clk);
        #1;
        rn_rf = rf_m[rn_a];
        rm_rf = rf_m[rm_a];
        if (e_we) begin
            rf_m[e_wa] = e_wd;
            inflight[e_wa]--;
        end
        if (e_pc_we) inflight[15]--;
        e_we    = 1'b0;
        e_pc_we = 1'b0;
        if (m_valid) begin
            d = m_link ? 4'd14 : m_wa;
            if (m_link)                       v = m_pc + 32'd4;
            else if (m_is_load && m_is_byte)  v = (m_ld_data >> (8 * (3 - int'(m_byte_off)))) & 32'hFF;
            else if (m_is_load)               v = m_ld_data;
            else                              v = m_alu;
            inflight[d]++;
            if (d == 4'd15) begin
                e_pc_we = 1'b1;
                e_pc_wd = v;
            end else begin
                e_we = 1'b1;
                e_wa = d;
                e_wd = v;
            end
        end
        e_rn_fwd = rf_m[rn_a];
        e_rm_fwd = rf_m[rm_a];
        @(negedge clk);
        for (int i = 0; i < 16; i++) ep[i] = (inflight[i] > 0);
        chk("we",      32'(we),    32'(e_we));
        chk("wa",      32'(wa),    32'(e_wa));
        chk("wd",      wd,         e_wd);
        chk("pc_we",   32'(pc_we), 32'(e_pc_we));
        chk("pc_wd",   pc_wd,      e_pc_wd);
        chk("pending", 32'(pending), 32'(ep));
        chk("rn_fwd",  rn_fwd,     e_rn_fwd);
        chk("rm_fwd",  rm_fwd,     e_rm_fwd);
    endtask

    initial begin
        rst   = 1'b1;
        rn_rf = '0;
        rm_rf = '0;
        idle(4'd0, 4'd0);
        for (int i = 0; i < 16; i++) rf_m[i] = '0;
        clear_model();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",      32'(we),      32'd0);
        chk("rst_wa",      32'(wa),      32'd0);
        chk("rst_wd",      wd,           32'd0);
        chk("rst_pc_we",   32'(pc_we),   32'd0);
        chk("rst_pc_wd",   pc_wd,        32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_rn_fwd",  rn_fwd,       rn_rf);
        rst = 1'b0;

        // ALU result to r3
        drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 4'd0, 4'd0);
        step();
        chk("alu_we",   32'(we), 32'd1);
        chk("alu_wa",   32'(wa), 32'd3);
        chk("alu_wd",   wd,      32'hDEADBEEF);
        chk("alu_pend", 32'(pending[3]), 32'd1);
        idle(4'd0, 4'd0);
        step();
        chk("alu_pend_clr", 32'(pending[3]), 32'd0);
        chk("idle_we",      32'(we),         32'd0);

        // Byte and word loads
        drive(1'b1, 4'd4, 32'd0, 1'b1, 1'b1, 1'b0, 32'h11223344, 2'd2, 32'd0, 4'd0, 4'd0);
        step();
        chk("ldrb_off2", wd, 32'h00000033);
        drive(1'b1, 4'd4, 32'd0, 1'b1, 1'b1, 1'b0, 32'h11223344, 2'd0, 32'd0, 4'd0, 4'd0);
        step();
        chk("ldrb_off0", wd, 32'h00000011);
        drive(1'b1, 4'd4, 32'd0, 1'b1, 1'b0, 1'b0, 32'h11223344, 2'd3, 32'd0, 4'd0, 4'd0);
        step();
        chk("ldr_word", wd, 32'h11223344);

        // Branch-with-link, then a write to r15
        drive(1'b1, 4'd9, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, 2'd0, 32'h100, 4'd0, 4'd0);
        step();
        chk("bl_wa", 32'(wa), 32'd14);
        chk("bl_wd", wd,      32'h104);
        drive(1'b1, 4'd15, 32'h200, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 4'd0, 4'd0);
        step();
        chk("pc_we_set", 32'(pc_we), 32'd1);
        chk("pc_wd_val", pc_wd,      32'h200);
        chk("pc_no_rf",  32'(we),    32'd0);

        // Bypass over a stale RF read
        drive(1'b1, 4'd5, 32'h55, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 4'd0, 4'd0);
        step();
        idle(4'd5, 4'd5);
        step();
        chk("byp_rn_stale", rn_rf,  32'd0);
        chk("byp_rn",       rn_fwd, 32'h55);
        chk("byp_rm",       rm_fwd, 32'h55);
        idle(4'd6, 4'd5);
        step();
        chk("byp_miss", rn_fwd, rn_rf);

        // Back-to-back writes to r2, then link and load racing for r14
        drive(1'b1, 4'd2, 32'h1, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 4'd0, 4'd0);
        step();
        chk("b2b_pend1", 32'(pending[2]), 32'd1);
        drive(1'b1, 4'd2, 32'h2, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 4'd0, 4'd0);
        step();
        chk("b2b_pend2", 32'(pending[2]), 32'd1);
        chk("b2b_wd2",   wd,              32'h2);
        drive(1'b1, 4'd14, 32'd0, 1'b1, 1'b0, 1'b0, 32'hAAAA5555, 2'd0, 32'd0, 4'd2, 4'd0);
        step();
        chk("b2b_pend_clr", 32'(pending[2]), 32'd0);
        drive(1'b1, 4'd3, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, 2'd0, 32'h400, 4'd14, 4'd14);
        step();
        chk("lr_later_wins", wd, 32'h404);

        // Reset in the middle of an outgoing write
        drive(1'b1, 4'd7, 32'h77, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 4'd5, 4'd7);
        step();
        chk("pre_rst_we", 32'(we), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we",      32'(we),      32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_rn_fwd",  rn_fwd,       rn_rf);
        chk("mid_rst_rm_fwd",  rm_fwd,       rm_rf);
        clear_model();
        idle(4'd7, 4'd7);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("rst_no_write", rn_fwd, 32'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom, 2'($urandom_range(0, 3)),
                  $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
